// File: rtl/use_stream_collector_pkg.sv
// Shared types and defaults for the stream element collector and its serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package use_stream_pkg;

    localparam int DATA_BUS_WIDTH_BYTES_DFLT = 8;
    localparam int MAX_RECORD_BYTES_DFLT     = 34;

    // One stream byte, same shape as the StreamElement record storage.
    typedef logic [7:0] byte_t;

    // Collector control: look for a ready element, or stream out the captured record.
    typedef enum logic {
        SCAN = 1'b0,
        SEND = 1'b1
    } state_t;

    // Bits needed to hold a length in the range 0..n.
    function automatic int len_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/use_stream_collector_if.sv
// AXI4-Stream beat bundle between the collector and the downstream consumer.
// Latency: n/a (wiring only).
// Backpressure: tready from the slave stalls the master; payload holds while stalled.
interface use_stream_collector_if #(
    parameter int DATA_BUS_WIDTH_BYTES = 8
);

    logic [DATA_BUS_WIDTH_BYTES*8-1:0] tdata;
    logic [DATA_BUS_WIDTH_BYTES-1:0]   tkeep;
    logic                              tvalid;
    logic                              tready;
    logic                              tlast;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/use_stream_collector_serializer.sv
// Holds one captured record and emits it as AXI4-Stream beats with tkeep/tlast.
// Latency: first beat is valid the cycle after load; one beat per accepted handshake.
// Backpressure: beat index only advances on tvalid & tready, so payload is stable while stalled.
module use_record_serializer
    import use_stream_pkg::*;
#(
    parameter int DATA_BUS_WIDTH_BYTES = DATA_BUS_WIDTH_BYTES_DFLT,
    parameter int MAX_RECORD_BYTES     = MAX_RECORD_BYTES_DFLT,
    parameter int LW                   = 6,
    parameter int BW                   = 3
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         load,
    input  byte_t [MAX_RECORD_BYTES-1:0] load_data,
    input  logic [LW-1:0]                load_len,
    input  logic                         active,
    output logic                         rec_done,
    use_stream_collector_if.master       m_axis
);

    localparam int W  = DATA_BUS_WIDTH_BYTES;
    localparam int IW = (MAX_RECORD_BYTES > 1) ? $clog2(MAX_RECORD_BYTES) : 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_RECORD_BYTES);

    byte_t [MAX_RECORD_BYTES-1:0] rec_buf;
    logic [LW-1:0]                rec_len;
    logic [BW-1:0]                beat;

    // Byte offsets are one bit wider than a length so beat*W+i cannot wrap.
    logic [LW:0]                  base;
    logic [LW:0]                  idx;
    logic [LW:0]                  len_ext;
    logic                         last;
    logic [W*8-1:0]               beat_data;
    logic [W-1:0]                 beat_keep;

    // Record bytes are only read while a record is active, so they carry no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            rec_buf <= load_data;
        end
    end

    // Length latch (clamped to the buffer size) and beat index within the record.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rec_len <= '0;
            beat    <= '0;
        end else if (load) begin
            rec_len <= (load_len > MAX_LEN) ? MAX_LEN : load_len;
            beat    <= '0;
        end else if (active && m_axis.tready && !last) begin
            beat <= beat + BW'(1);
        end
    end

    // Build the current beat: valid bytes from the buffer, zero padding past the end.
    always_comb begin
        len_ext   = {1'b0, rec_len};
        base      = (LW+1)'(beat) * (LW+1)'(W);
        last      = ((base + (LW+1)'(W)) >= len_ext);
        idx       = '0;
        beat_data = '0;
        beat_keep = '0;
        for (int i = 0; i < W; i++) begin
            idx = base + (LW+1)'(i);
            if (idx < len_ext) begin
                beat_keep[i]       = 1'b1;
                beat_data[8*i +: 8] = rec_buf[IW'(idx)];
            end
        end
    end

    // Outputs are forced to zero outside a record so the idle bus is quiet.
    assign m_axis.tvalid = active;
    assign m_axis.tdata  = active ? beat_data : '0;
    assign m_axis.tkeep  = active ? beat_keep : '0;
    assign m_axis.tlast  = active & last;
    assign rec_done      = active & m_axis.tready & last;

endmodule

// File: rtl/use_stream_collector.sv
// Polls stream elements in token order, captures each completed record and streams it out.
// Latency: first beat is valid one cycle after a nonzero length is seen; one idle cycle between records.
// Backpressure: tready stalls the current beat; no new element is captured until the record ends.
module use_stream_collector
    import use_stream_pkg::*;
#(
    parameter int NUM_ELEMENTS         = 4,
    parameter int DATA_BUS_WIDTH_BYTES = DATA_BUS_WIDTH_BYTES_DFLT,
    parameter int MAX_RECORD_BYTES     = MAX_RECORD_BYTES_DFLT,
    parameter int START_ID             = 0,
    localparam int LW                  = len_width(MAX_RECORD_BYTES)
) (
    input  logic                                             clk,
    input  logic                                             resetn,
    input  byte_t [NUM_ELEMENTS-1:0][MAX_RECORD_BYTES-1:0]   use_data,
    input  logic [NUM_ELEMENTS-1:0][LW-1:0]                  use_len,
    output logic [NUM_ELEMENTS-1:0]                          use_taken,
    use_stream_collector_if.master                           m_axis,
    output logic [15:0]                                      records_out
);

    localparam int PW    = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam int BEATS = (MAX_RECORD_BYTES + DATA_BUS_WIDTH_BYTES - 1) / DATA_BUS_WIDTH_BYTES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t                       state;
    state_t                       state_nxt;
    logic [PW-1:0]                ptr;
    logic [PW-1:0]                ptr_nxt;
    logic [LW-1:0]                sel_len;
    byte_t [MAX_RECORD_BYTES-1:0] sel_data;
    logic [NUM_ELEMENTS-1:0]      taken_nxt;
    logic                         capture;
    logic                         send_active;
    logic                         rec_done;

    // Only the token holder is looked at; ready elements elsewhere must wait their turn.
    always_comb begin
        sel_len  = '0;
        sel_data = '0;
        for (int e = 0; e < NUM_ELEMENTS; e++) begin
            if (ptr == PW'(e)) begin
                sel_len  = use_len[e];
                sel_data = use_data[e];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: capture when the token holder has a record, return after the last beat.
    always_comb begin
        state_nxt = state;
        case (state)
            SCAN:    if (sel_len != '0) state_nxt = SEND;
            SEND:    if (rec_done)      state_nxt = SCAN;
            default: state_nxt = SCAN;
        endcase
    end

    // State-decoded controls for the capture path and the serializer.
    always_comb begin
        capture     = (state == SCAN) && (sel_len != '0);
        send_active = (state == SEND);
    end

    // Acknowledge pulse for the captured element and the following token position.
    always_comb begin
        taken_nxt = '0;
        for (int e = 0; e < NUM_ELEMENTS; e++) begin
            if (capture && (ptr == PW'(e))) begin
                taken_nxt[e] = 1'b1;
            end
        end
        ptr_nxt = (ptr == PW'(NUM_ELEMENTS - 1)) ? '0 : ptr + PW'(1);
    end

    // Token pointer advances on each capture; use_taken is a registered one-cycle pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr       <= PW'(START_ID);
            use_taken <= '0;
        end else begin
            use_taken <= taken_nxt;
            if (capture) begin
                ptr <= ptr_nxt;
            end
        end
    end

    // Completed-record counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            records_out <= '0;
        end else if (rec_done) begin
            records_out <= records_out + 16'd1;
        end
    end

    use_record_serializer #(
        .DATA_BUS_WIDTH_BYTES (DATA_BUS_WIDTH_BYTES),
        .MAX_RECORD_BYTES     (MAX_RECORD_BYTES),
        .LW                   (LW),
        .BW                   (BW)
    ) u_serializer (
        .clk       (clk),
        .resetn    (resetn),
        .load      (capture),
        .load_data (sel_data),
        .load_len  (sel_len),
        .active    (send_active),
        .rec_done  (rec_done),
        .m_axis    (m_axis)
    );

endmodule

// File: tb/tb_use_stream_collector.sv
// Bench for use_stream_collector: directed sequences, a table of record lengths and a
// randomized run against a record-level scoreboard; a second instance covers one element.
module tb_use_stream_collector;
    import use_stream_pkg::*;

    localparam int NE   = 4;
    localparam int W    = 8;
    localparam int MAX  = 34;
    localparam int LW   = len_width(MAX);
    localparam int NREC = 256;

    logic                        clk = 1'b0;
    logic                        resetn;
    logic [NE-1:0][MAX-1:0][7:0] use_data;
    logic [NE-1:0][LW-1:0]       use_len;
    logic [NE-1:0]               use_taken;
    logic [15:0]                 records_out;
    logic [0:0][MAX-1:0][7:0]    use_data1;
    logic [0:0][LW-1:0]          use_len1;
    logic [0:0]                  use_taken1;
    logic [15:0]                 records_out1;

    use_stream_collector_if #(.DATA_BUS_WIDTH_BYTES(W)) m_axis ();
    use_stream_collector_if #(.DATA_BUS_WIDTH_BYTES(W)) m_axis1 ();

    use_stream_collector #(
        .NUM_ELEMENTS(NE), .DATA_BUS_WIDTH_BYTES(W), .MAX_RECORD_BYTES(MAX), .START_ID(0)
    ) dut (
        .clk(clk), .resetn(resetn), .use_data(use_data), .use_len(use_len),
        .use_taken(use_taken), .m_axis(m_axis), .records_out(records_out)
    );

    use_stream_collector #(
        .NUM_ELEMENTS(1), .DATA_BUS_WIDTH_BYTES(W), .MAX_RECORD_BYTES(MAX), .START_ID(0)
    ) dut1 (
        .clk(clk), .resetn(resetn), .use_data(use_data1), .use_len(use_len1),
        .use_taken(use_taken1), .m_axis(m_axis1), .records_out(records_out1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: records in the order they were offered (which is token order).
    int          exp_len   [NREC];
    logic [7:0]  exp_bytes [NREC][MAX];
    int          pushed_cnt = 0;
    int          recv_cnt   = 0;
    int          flush_to   = 0;
    int          done_cnt   = 0;
    int          mon_n      = 0;
    bit          mon_stall  = 1'b0;
    logic [W*8-1:0] prev_data;
    logic [W-1:0]   prev_keep;
    logic           prev_last;
    int          rec1_cnt   = 0;
    int          next_elem  = 0;
    logic [NE-1:0] taken_prev;
    logic [0:0]    taken1_prev;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // One clock; elements drop their length the cycle after use_taken and scramble their data.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int e = 0; e < NE; e++) begin
            if (taken_prev[e]) begin
                use_len[e] = '0;
                for (int b = 0; b < MAX; b++) use_data[e][b] = 8'($urandom);
            end
        end
        taken_prev = use_taken;
        if (taken1_prev[0]) use_len1[0] = '0;
        taken1_prev = use_taken1;
    endtask

    task automatic present(input int e, input int len, input bit rnd);
        logic [7:0] v;
        for (int b = 0; b < MAX; b++) begin
            v = rnd ? 8'($urandom) : 8'(b);
            use_data[e][b] = v;
            exp_bytes[pushed_cnt][b] = v;
        end
        exp_len[pushed_cnt] = (len > MAX) ? MAX : len;
        pushed_cnt++;
        use_len[e] = LW'(len);
        next_elem = (e + 1) % NE;
    endtask

    // Runs one record with tready high; reports beat count, last tkeep and early use_taken.
    task automatic run_record(output int beats, output logic [7:0] last_keep,
                              output logic [NE-1:0] tk0, output logic [NE-1:0] tk1,
                              output logic first_valid);
        bit done;
        beats = 0; last_keep = '0; tk0 = '0; tk1 = '0; first_valid = 1'b0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (c == 0) begin tk0 = use_taken; first_valid = m_axis.tvalid; end
            if (c == 1) tk1 = use_taken;
            if (m_axis.tvalid) begin
                beats++;
                last_keep = m_axis.tkeep;
                if (m_axis.tlast && m_axis.tready) done = 1'b1;
            end
        end
        check("record_done", 64'(done), 64'(1));
        tick();
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && !(recv_cnt == pushed_cnt && !m_axis.tvalid); c++) tick();
        check("drain", 64'(recv_cnt), 64'(pushed_cnt));
    endtask

    // Beat monitor: every valid beat is compared with the next expected record slice.
    always @(negedge clk) begin
        int rem;
        logic [W-1:0]   ekeep;
        logic [W*8-1:0] edata;
        if (!resetn) begin
            mon_n     = 0;
            mon_stall = 1'b0;
            done_cnt  = 0;
            recv_cnt  = flush_to;
        end else begin
            check("records_out", 64'(records_out), 64'(done_cnt[15:0]));
            check("taken_onehot", 64'($countones(use_taken) <= 1), 64'(1));
            if (m_axis.tvalid) begin
                if (mon_stall) begin
                    check("hold_tdata", 64'(m_axis.tdata), 64'(prev_data));
                    check("hold_tkeep", 64'(m_axis.tkeep), 64'(prev_keep));
                    check("hold_tlast", 64'(m_axis.tlast), 64'(prev_last));
                end
                if (recv_cnt >= pushed_cnt) begin
                    check("beat_without_record", 64'(m_axis.tvalid), 64'(0));
                end else begin
                    rem   = exp_len[recv_cnt] - mon_n;
                    ekeep = '0;
                    edata = '0;
                    for (int i = 0; i < W; i++) begin
                        if (i < rem) begin
                            ekeep[i] = 1'b1;
                            edata[8*i +: 8] = exp_bytes[recv_cnt][mon_n + i];
                        end
                    end
                    check("tkeep", 64'(m_axis.tkeep), 64'(ekeep));
                    check("tdata", 64'(m_axis.tdata), 64'(edata));
                    check("tlast", 64'(m_axis.tlast), 64'(rem <= W));
                    if (m_axis.tready) begin
                        if (rem <= W) begin
                            recv_cnt++;
                            mon_n = 0;
                            done_cnt++;
                        end else begin
                            mon_n += W;
                        end
                    end
                end
                mon_stall = !m_axis.tready;
                prev_data = m_axis.tdata;
                prev_keep = m_axis.tkeep;
                prev_last = m_axis.tlast;
            end else begin
                if (mon_stall) check("tvalid_held", 64'(m_axis.tvalid), 64'(1));
                mon_stall = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && m_axis1.tvalid && m_axis1.tready && m_axis1.tlast) rec1_cnt++;
    end

    typedef struct {
        int         len;
        int         beats;
        logic [7:0] last_keep;
    } vec_t;

    initial begin
        vec_t          vt [8];
        int            beats;
        int            nt;
        int            len;
        int            exp_rec;
        int            target;
        logic [7:0]    lkeep;
        logic [NE-1:0] tk0, tk1, t1, t2;
        logic          fv;
        logic [W*8-1:0] snap_data;
        logic [W-1:0]   snap_keep;
        logic           snap_last;

        vt[0] = '{16, 2, 8'hFF};
        vt[1] = '{34, 5, 8'h03};
        vt[2] = '{1,  1, 8'h01};
        vt[3] = '{8,  1, 8'hFF};
        vt[4] = '{9,  2, 8'h01};
        vt[5] = '{40, 5, 8'h03};
        vt[6] = '{63, 5, 8'h03};
        vt[7] = '{7,  1, 8'h7F};

        resetn = 1'b0;
        m_axis.tready = 1'b1;
        m_axis1.tready = 1'b1;
        use_data = '0;
        use_len = '0;
        use_data1 = '0;
        use_len1 = '0;
        taken_prev = '0;
        taken1_prev = '0;
        exp_rec = 0;
        for (int b = 0; b < MAX; b++) use_data1[0][b] = 8'(b + 8'h40);

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(m_axis.tvalid), 64'(0));
        check("rst_tdata", 64'(m_axis.tdata), 64'(0));
        check("rst_tkeep", 64'(m_axis.tkeep), 64'(0));
        check("rst_tlast", 64'(m_axis.tlast), 64'(0));
        check("rst_taken", 64'(use_taken), 64'(0));
        check("rst_records", 64'(records_out), 64'(0));
        resetn = 1'b1;

        // Element 0, 23 bytes 0x00..0x16.
        present(0, 23, 1'b0);
        run_record(beats, lkeep, tk0, tk1, fv);
        exp_rec++;
        check("t1_taken_pulse", 64'(tk0), 64'(4'b0001));
        check("t1_taken_clear", 64'(tk1), 64'(4'b0000));
        check("t1_latency", 64'(fv), 64'(1));
        check("t1_beats", 64'(beats), 64'(3));
        check("t1_last_keep", 64'(lkeep), 64'(8'h7F));
        check("t1_records", 64'(records_out), 64'(exp_rec));

        // Elements 1 and 2 ready together: token order serves 1 then 2.
        present(1, 5, 1'b1);
        present(2, 12, 1'b1);
        nt = 0; t1 = '0; t2 = '0;
        for (int c = 0; c < 60 && !(nt >= 2 && recv_cnt == pushed_cnt && !m_axis.tvalid); c++) begin
            tick();
            if (use_taken != '0) begin
                if (nt == 0) t1 = use_taken;
                else if (nt == 1) t2 = use_taken;
                nt++;
            end
        end
        exp_rec += 2;
        check("order_first", 64'(t1), 64'(4'b0010));
        check("order_second", 64'(t2), 64'(4'b0100));
        check("order_records", 64'(records_out), 64'(exp_rec));

        // Length table.
        for (int k = 0; k < 8; k++) begin
            present(next_elem, vt[k].len, 1'b1);
            run_record(beats, lkeep, tk0, tk1, fv);
            exp_rec++;
            check("tbl_beats", 64'(beats), 64'(vt[k].beats));
            check("tbl_last_keep", 64'(lkeep), 64'(vt[k].last_keep));
            check("tbl_records", 64'(records_out), 64'(exp_rec));
        end

        // Backpressure on beat 1 of a 20-byte record.
        present(next_elem, 20, 1'b1);
        tick();
        tick();
        m_axis.tready = 1'b0;
        snap_data = m_axis.tdata;
        snap_keep = m_axis.tkeep;
        snap_last = m_axis.tlast;
        check("bp_beat1_keep", 64'(snap_keep), 64'(8'hFF));
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_tvalid", 64'(m_axis.tvalid), 64'(1));
            check("bp_tdata", 64'(m_axis.tdata), 64'(snap_data));
            check("bp_tkeep", 64'(m_axis.tkeep), 64'(snap_keep));
            check("bp_tlast", 64'(m_axis.tlast), 64'(snap_last));
        end
        m_axis.tready = 1'b1;
        tick();
        check("bp_beat2_keep", 64'(m_axis.tkeep), 64'(8'h0F));
        check("bp_beat2_last", 64'(m_axis.tlast), 64'(1));
        wait_drain(20);
        exp_rec++;
        check("bp_records", 64'(records_out), 64'(exp_rec));

        // Reset in the middle of a record.
        present(next_elem, 34, 1'b1);
        tick();
        tick();
        #2;
        flush_to = pushed_cnt;
        resetn = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_axis.tvalid), 64'(0));
        check("mid_rst_tdata", 64'(m_axis.tdata), 64'(0));
        check("mid_rst_tkeep", 64'(m_axis.tkeep), 64'(0));
        check("mid_rst_tlast", 64'(m_axis.tlast), 64'(0));
        check("mid_rst_taken", 64'(use_taken), 64'(0));
        check("mid_rst_records", 64'(records_out), 64'(0));
        use_len = '0;
        taken_prev = '0;
        taken1_prev = '0;
        next_elem = 0;
        exp_rec = 0;
        tick();
        tick();
        resetn = 1'b1;
        present(0, 10, 1'b1);
        tick();
        check("post_rst_first", 64'(use_taken), 64'(4'b0001));
        check("post_rst_records0", 64'(records_out), 64'(0));
        wait_drain(20);
        exp_rec++;
        check("post_rst_records1", 64'(records_out), 64'(exp_rec));

        // Single element: length lingers one cycle after taken, must not be recaptured.
        use_len1[0] = LW'(5);
        nt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (use_taken1[0]) nt++;
        end
        check("one_elem_taken", 64'(nt), 64'(1));
        check("one_elem_records", 64'(records_out1), 64'(1));
        check("one_elem_beats", 64'(rec1_cnt), 64'(1));

        // Randomized records with random backpressure.
        target = pushed_cnt + 120;
        for (int c = 0; c < 20000 && !(pushed_cnt >= target && recv_cnt == pushed_cnt && !m_axis.tvalid); c++) begin
            m_axis.tready = ($urandom_range(3) != 0);
            if (pushed_cnt < target && use_len[next_elem] == '0 && $urandom_range(2) == 0) begin
                len = ($urandom_range(7) == 0) ? int'($urandom_range(63, MAX + 1)) : int'($urandom_range(MAX, 1));
                present(next_elem, len, 1'b1);
            end
            tick();
        end
        m_axis.tready = 1'b1;
        exp_rec += 120;
        check("rand_drain", 64'(recv_cnt), 64'(pushed_cnt));
        check("rand_records", 64'(records_out), 64'(exp_rec % 65536));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
